dickson_led_meter: RTL and testbench
====================================

# dickson_led_meter

Measures how often an asynchronous on/off signal toggles, such as an LED drive line or an external blinker, and reports the interval between consecutive toggles in milliseconds. It is the receive-side counterpart of the LED blinker: a blinker driven with rate `N` ms, looped into this block, reads back as `N`. The block sits on the 100 MHz fabric clock and presents results to the CPU/MMIO wrapper through a valid/ready register.

## Interface
- `CLK_FREQ_MHZ`, 100: clock frequency in integer MHz. `C` = CLK_FREQ_MHZ*1000 cycles per ms.
- `TIMEOUT_MS`, 65535: largest reportable interval in ms. Range 1..65535.
- `FILTER_CYCLES`, 16: glitch-filter stability length, used only when `DICKSON_METER_FILTER_EN` is defined.
- `clk` in 1: single clock for the block.
- `reset` in 1: synchronous, active-low reset.
- `sig_in` in 1: asynchronous input to be measured.
- `rate_ready` in 1: consumer accepts the current result.
- `rate_ms` out 16: latest interval in ms. Value 0 means timeout (input stopped).
- `rate_valid` out 1: `rate_ms` holds an unconsumed result.
- `overrun` out 1: one-cycle pulse when an unconsumed result is overwritten.

## Operation
- `sig_in` passes through a 2-FF synchronizer (optional filter follows). An edge pulse `e` is generated on either transition of the conditioned signal.
- `k` is the number of clock cycles between two consecutive `e` pulses. The reported value is floor((k + C/2)/C), clamped to a minimum of 1.
- State machine:
  - `IDLE` is entered after reset and after a timeout. On the first `e`, clear the elapsed counters and go to `MEASURE`; nothing is reported.
  - In `MEASURE`, each `e` reports the rounded value, restarts the counters, and the machine stays in `MEASURE`.
  - In `MEASURE`, when the elapsed cycle count reaches TIMEOUT_MS*C + C/2 (the rounded value would exceed TIMEOUT_MS), report 0 and go to `IDLE`.
- Counters:
  - Cycle prescaler is 0..C-1. The ms counter is 16 bits.
  - Rounding uses the prescaler residue: add 1 when residue ≥ C/2.
  - No 32-bit multiply is used.
- Result register:
  - A report loads `rate_ms` and sets `rate_valid`.
  - `rate_valid && rate_ready` with no report in that cycle clears `rate_valid`.
  - A report in the same cycle as ready loads the new value and keeps `rate_valid`=1, with no overrun.
  - A report while `rate_valid`=1 and `rate_ready`=0 overwrites the value and pulses `overrun`.
- Reset applies in any state, including mid-measurement. The in-progress interval is discarded.

## Timing
- Reset values: `rate_ms`=0, `rate_valid`=0, `overrun`=0, state `IDLE`, synchronizer flops 0, all counters 0.
- `sig_in` transition to `rate_valid`/`rate_ms` update takes 3 clk edges: 2 for sync, 1 for the registered output. The filter adds FILTER_CYCLES on top.
- The latency is identical for rising and falling edges, so `k` equals the true toggle spacing.
- A timeout report appears on the cycle the threshold count is reached.
- `rate_ready` is sampled on `clk`. There is no combinational path from `rate_ready` to any output.

## Configuration
- `DICKSON_METER_FILTER_EN` defined:
  - The synchronized input must stay at its new level for FILTER_CYCLES consecutive cycles before the conditioned signal changes.
  - Shorter pulses are ignored entirely, and neither counter is affected.
- `DICKSON_METER_FILTER_EN` not defined:
  - The synchronizer output drives edge detection directly.
  - `FILTER_CYCLES` is unused.

## Structure
- Package `dickson_meter_pkg` holds:
  - state enum `meter_state_t` {IDLE, MEASURE};
  - function `cycles_per_ms(CLK_FREQ_MHZ)`;
  - localparam for the 16-bit rate width.
- Sub-module `dickson_edge_sync` contains the synchronizer, the optional filter and the edge pulse.
- The top module keeps the FSM, counters and result register.

## Test plan
All tests use CLK_FREQ_MHZ=1 (C=1000) and TIMEOUT_MS=50.
- **Basic measurement.** Toggle `sig_in` every 5000 cycles, `rate_ready`=1. The first toggle reports nothing; the next and every later toggle give `rate_ms`=5, `rate_valid` high 1 cycle, 3 cycles after the toggle.
- **Rounding and clamp.** Toggle spacings of 1499, 1500 and 300 cycles give 1, 2 and 1.
- **Timeout.** After one 5000-cycle interval, hold `sig_in`. `rate_ms`=0 reports at 50500 cycles after the last edge, and the FSM returns to `IDLE`. The next toggle reports nothing.
- **Handshake and overrun.** Hold `rate_ready`=0 across two reports (4 then 7). `overrun` pulses once and `rate_ms`=7 stays valid until ready. Assert ready in the same cycle as a report: valid stays 1 and there is no overrun.
- **Reset mid-measurement.** Assert `reset`=0 2000 cycles into an interval: all outputs go to 0 on the next clock. After release, the first toggle reports nothing.
- **Glitch filter** (`DICKSON_METER_FILTER_EN` defined, FILTER_CYCLES=16). A 10-cycle glitch inside a 3000-cycle interval still reads 3. Without the macro, the same stimulus produces two extra reports.

Source files
------------

// File: rtl/dickson_meter_pkg.sv
// Shared types and helpers for the toggle-interval meter.
package dickson_meter_pkg;

  localparam int RATE_W = 16;

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    MEASURE = 1'b1
  } meter_state_t;

  function automatic int cycles_per_ms(input int clk_freq_mhz);
    return clk_freq_mhz * 32'sd1000;
  endfunction

endpackage

// File: rtl/dickson_edge_sync.sv
// Synchronizes sig_in, optionally glitch-filters it (DICKSON_METER_FILTER_EN),
// and emits a one-cycle pulse on either transition of the conditioned level.
module dickson_edge_sync #(
  parameter int FILTER_CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic sig_in,
  output logic edge_pulse
);

  logic sync1_r;
  logic sync2_r;
  logic cond_s;
  logic cond_prev_r;

  // Two-flop synchronizer for the asynchronous input.
  always_ff @(posedge clk) begin
    if (!reset) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
    end else begin
      sync1_r <= sig_in;
      sync2_r <= sync1_r;
    end
  end

`ifdef DICKSON_METER_FILTER_EN
  localparam int FCW = $clog2(FILTER_CYCLES + 1);

  logic           filt_r;
  logic [FCW-1:0] fcnt_r;

  // Conditioned level only follows after FILTER_CYCLES stable cycles.
  always_ff @(posedge clk) begin
    if (!reset) begin
      filt_r <= 1'b0;
      fcnt_r <= '0;
    end else if (sync2_r != filt_r) begin
      if (fcnt_r == FCW'(FILTER_CYCLES - 1)) begin
        filt_r <= sync2_r;
        fcnt_r <= '0;
      end else begin
        fcnt_r <= fcnt_r + {{(FCW-1){1'b0}}, 1'b1};
      end
    end else begin
      fcnt_r <= '0;
    end
  end

  assign cond_s = filt_r;
`else
  logic unused_filter_s;
  assign unused_filter_s = (FILTER_CYCLES > 32'sd0);
  assign cond_s          = sync2_r;
`endif

  // Previous conditioned level for transition detection.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cond_prev_r <= 1'b0;
    end else begin
      cond_prev_r <= cond_s;
    end
  end

  assign edge_pulse = cond_s ^ cond_prev_r;

endmodule

// File: rtl/dickson_led_meter.sv
// Measures the spacing between toggles of sig_in in rounded milliseconds and
// presents it through a valid/ready result register. Filter: DICKSON_METER_FILTER_EN.
module dickson_led_meter
  import dickson_meter_pkg::*;
#(
  parameter int CLK_FREQ_MHZ  = 100,
  parameter int TIMEOUT_MS    = 65535,
  parameter int FILTER_CYCLES = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sig_in,
  input  logic              rate_ready,
  output logic [RATE_W-1:0] rate_ms,
  output logic              rate_valid,
  output logic              overrun
);

  localparam int C    = cycles_per_ms(CLK_FREQ_MHZ);
  localparam int HALF = C / 2;
  localparam int PW   = $clog2(C);

  meter_state_t      state_r;
  meter_state_t      state_nxt_s;
  logic [PW-1:0]     presc_r;
  logic [RATE_W-1:0] ms_r;
  logic              edge_s;
  logic              at_timeout_s;
  logic              round_up_s;
  logic [RATE_W-1:0] rounded_s;
  logic [RATE_W-1:0] rate_calc_s;
  logic              report_s;
  logic [RATE_W-1:0] report_val_s;
  logic              load_s;

  dickson_edge_sync #(
    .FILTER_CYCLES (FILTER_CYCLES)
  ) u_edge_sync (
    .clk        (clk),
    .reset      (reset),
    .sig_in     (sig_in),
    .edge_pulse (edge_s)
  );

  // Elapsed count is ms_r*C + presc_r; the timeout point is where rounding would pass TIMEOUT_MS.
  assign at_timeout_s = (state_r == MEASURE) && (ms_r == RATE_W'(TIMEOUT_MS)) &&
                        (presc_r == PW'(HALF));
  assign round_up_s   = (presc_r >= PW'(HALF));
  assign rounded_s    = ms_r + {{(RATE_W-1){1'b0}}, round_up_s};
  assign rate_calc_s  = (rounded_s == {RATE_W{1'b0}}) ? {{(RATE_W-1){1'b0}}, 1'b1} : rounded_s;

  // Next-state and report decode; timeout wins over a coincident edge.
  always_comb begin
    state_nxt_s  = state_r;
    report_s     = 1'b0;
    report_val_s = '0;
    load_s       = 1'b0;
    case (state_r)
      IDLE: begin
        if (edge_s) begin
          load_s      = 1'b1;
          state_nxt_s = MEASURE;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      MEASURE: begin
        if (at_timeout_s) begin
          report_s     = 1'b1;
          report_val_s = '0;
          state_nxt_s  = IDLE;
        end else if (edge_s) begin
          report_s     = 1'b1;
          report_val_s = rate_calc_s;
          load_s       = 1'b1;
          state_nxt_s  = MEASURE;
        end else begin
          state_nxt_s = MEASURE;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Elapsed-time counters; loading 1 on an edge makes the count equal the spacing k.
  always_ff @(posedge clk) begin
    if (!reset) begin
      presc_r <= '0;
      ms_r    <= '0;
    end else if (load_s) begin
      presc_r <= PW'(1);
      ms_r    <= '0;
    end else if (state_r == MEASURE && !at_timeout_s) begin
      if (presc_r == PW'(C - 1)) begin
        presc_r <= '0;
        ms_r    <= ms_r + {{(RATE_W-1){1'b0}}, 1'b1};
      end else begin
        presc_r <= presc_r + {{(PW-1){1'b0}}, 1'b1};
        ms_r    <= ms_r;
      end
    end else begin
      presc_r <= presc_r;
      ms_r    <= ms_r;
    end
  end

  // Result register with valid/ready handshake and overrun flag.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rate_ms    <= '0;
      rate_valid <= 1'b0;
      overrun    <= 1'b0;
    end else if (report_s) begin
      rate_ms    <= report_val_s;
      rate_valid <= 1'b1;
      overrun    <= rate_valid && !rate_ready;
    end else begin
      rate_ms    <= rate_ms;
      overrun    <= 1'b0;
      rate_valid <= rate_valid && !rate_ready;
    end
  end

endmodule

// File: tb/tb_dickson_led_meter.sv
// Randomized/directed bench for dickson_led_meter against an interval-level model.
module tb_dickson_led_meter;

  localparam int CLK_MHZ = 1;
  localparam int TMO_MS  = 50;
  localparam int C       = CLK_MHZ * 1000;
  localparam int THR     = TMO_MS * C + C / 2;

  logic        clk;
  logic        reset;
  logic        sig_in;
  logic        rate_ready;
  logic [15:0] rate_ms;
  logic        rate_valid;
  logic        overrun;

  dickson_led_meter #(
    .CLK_FREQ_MHZ  (CLK_MHZ),
    .TIMEOUT_MS    (TMO_MS),
    .FILTER_CYCLES (16)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .sig_in     (sig_in),
    .rate_ready (rate_ready),
    .rate_ms    (rate_ms),
    .rate_valid (rate_valid),
    .overrun    (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          edge_n   = 0;
  int          due_q[$];
  bit          m_meas   = 1'b0;
  int          m_last   = 0;
  bit          exp_valid = 1'b0;
  bit          exp_ovr   = 1'b0;
  int          exp_ms    = 0;

  task automatic check_val(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at edge %0d: got %0d expected %0d", tag, edge_n, got, exp);
    end
  endtask

  // Interval-level model: an edge seen at edge n reports round(k/C) with k = n - previous edge.
  task automatic model_update(input bit rst_smp, input bit rdy_smp);
    bit rep;
    bit e;
    int val;
    int k;
    e = 1'b0;
    if (due_q.size() > 0 && due_q[0] == edge_n) begin
      void'(due_q.pop_front());
      e = 1'b1;
    end
    if (!rst_smp) begin
      m_meas = 1'b0; exp_valid = 1'b0; exp_ovr = 1'b0; exp_ms = 0;
      due_q.delete();
    end else begin
      rep = 1'b0;
      val = 0;
      if (m_meas && (edge_n - m_last) == THR) begin
        rep = 1'b1; val = 0; m_meas = 1'b0;
      end else if (e) begin
        if (m_meas) begin
          k   = edge_n - m_last;
          val = (k + C / 2) / C;
          if (val < 1) val = 1;
          rep = 1'b1;
        end
        m_meas = 1'b1;
        m_last = edge_n;
      end
      if (rep) begin
        exp_ovr   = exp_valid && !rdy_smp;
        exp_valid = 1'b1;
        exp_ms    = val;
      end else begin
        exp_ovr = 1'b0;
        if (exp_valid && rdy_smp) exp_valid = 1'b0;
      end
    end
  endtask

  task automatic step();
    bit rst_smp;
    bit rdy_smp;
    rst_smp = reset;
    rdy_smp = rate_ready;
    @(posedge clk);
    edge_n++;
    model_update(rst_smp, rdy_smp);
    #1;
    check_val("rate_valid", 32'(rate_valid), 32'(exp_valid));
    check_val("overrun",    32'(overrun),    32'(exp_ovr));
    check_val("rate_ms",    32'(rate_ms),    exp_ms);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic run_rand(input int n);
    for (int i = 0; i < n; i++) begin
      rate_ready = ($urandom_range(0, 3) == 0);
      step();
    end
  endtask

  // Toggle applied now is sampled at the next edge and reaches the output two edges later.
  task automatic toggle();
    sig_in = ~sig_in;
    if (reset) due_q.push_back(edge_n + 3);
  endtask

  initial begin
    sig_in     = 1'b0;
    rate_ready = 1'b1;
    reset      = 1'b0;
    #1;
    run(4);
    reset = 1'b1;
    run(3);

    // Basic 5 ms spacing, then hold until timeout.
    toggle(); run(5000);
    toggle(); run(5000);
    toggle(); run(THR + 10);

    // First toggle after timeout is silent; rounding and clamp.
    toggle(); run(1499);
    toggle(); run(1500);
    toggle(); run(300);
    toggle(); run(20);

    // Handshake: 4 then 7 with ready low, overrun on the second.
    rate_ready = 1'b0;
    run(3980);
    toggle(); run(7000);
    toggle(); run(50);
    rate_ready = 1'b1; run(1);
    rate_ready = 1'b0; run(1949);
    toggle(); run(1000);
    toggle(); run(2);
    rate_ready = 1'b1; run(1);
    run(5);

    // Reset mid-measurement, then a silent first toggle.
    toggle(); run(2000);
    reset  = 1'b0;
    sig_in = 1'b0;
    run(4);
    reset = 1'b1;
    run(5);
    toggle(); run(1000);
    toggle(); run(20);

    // Short glitch inside a 3 ms interval (unfiltered build reports it).
    toggle(); run(1000);
    toggle(); run(10);
    toggle(); run(1990);
    toggle(); run(20);

    // Randomized spacings with random ready.
    for (int j = 0; j < 5; j++) begin
      toggle();
      run_rand($urandom_range(100, 1200));
    end
    rate_ready = 1'b1;
    run(10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
